// File: rtl/vga_char_fifo.sv
// Character FIFO between the bus-side register write and the text console.
// Characters are issued one at a time and spaced out so the console keeps up; scroll pauses the drain.
module vga_char_fifo #(
  parameter int DEPTH = 16,
  parameter int GAP   = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       scroll,
  input  logic                       ovf_clr,
  output logic                       font_we,
  output logic [7:0]                 font_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  // state | meaning
  // IDLE  | waiting for a character and scroll=0
  // ISSUE | font_we strobe cycle for the popped character
  // HOLD  | gap countdown; also parks here while scroll=1
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          font_we_q, font_we_d;
  logic [7:0]    font_data_q, font_data_d;
  logic [3:0]    gap_q, gap_d;
  state_t        state_q, state_d;

  logic full_int, empty_int, push, drop, pop;

  assign full_int  = (count_q == CW'(DEPTH));
  assign empty_int = (count_q == '0);
  assign push      = wr_en && !full_int;
  assign drop      = wr_en && full_int;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    pop         = 1'b0;
    font_we_d   = 1'b0;
    font_data_d = font_data_q;
    case (state_q)
      IDLE: begin
        if (!empty_int && !scroll) begin
          pop         = 1'b1;
          font_we_d   = 1'b1;
          font_data_d = mem_q[rd_ptr_q];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = HOLD;
        gap_d   = 4'(GAP);
      end
      HOLD: begin
        // leaving on the cycle the counter reaches zero gives GAP+2 spacing
        gap_d = (gap_q == 4'd0) ? 4'd0 : gap_q - 4'd1;
        if (gap_d == 4'd0 && !scroll) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      font_we_q   <= 1'b0;
      font_data_q <= 8'h00;
      gap_q       <= 4'd0;
      state_q     <= IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      font_we_q   <= font_we_d;
      font_data_q <= font_data_d;
      gap_q       <= gap_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign font_we   = font_we_q;
  assign font_data = font_data_q;
  assign full      = full_int;
  assign empty     = empty_int;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vga_char_fifo.sv
// Directed bench for vga_char_fifo (DEPTH=16, GAP=2); inputs change and outputs are sampled on the falling edge.
module tb_vga_char_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       scroll;
  logic       ovf_clr;
  logic       font_we;
  logic [7:0] font_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  vga_char_fifo #(.DEPTH(16), .GAP(2)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .scroll(scroll), .ovf_clr(ovf_clr), .font_we(font_we), .font_data(font_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_strobe(input int max_cyc, output logic [7:0] d, output int cyc, output bit ok);
    ok  = 1'b0;
    d   = 8'h00;
    cyc = 0;
    while (!ok && cyc < max_cyc) begin
      step();
      cyc++;
      if (font_we) begin
        ok = 1'b1;
        d  = font_data;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] q[$];
    int cyc, strobes, got, t_prev, k;
    bit ok;

    resetn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; scroll = 1'b0; ovf_clr = 1'b0;
    #3;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_we", font_we, 0);
    check("rst_data", font_data, 8'h00);
    step(); step();
    resetn = 1'b1;
    step(); step();

    // single character latency
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    check("lat_count1", count, 1);
    check("lat_we_early", font_we, 0);
    step();
    check("lat_we", font_we, 1);
    check("lat_data", font_data, 8'h41);
    check("lat_count0", count, 0);
    check("lat_empty", empty, 1);
    step();
    check("lat_we_single", font_we, 0);
    check("lat_data_hold", font_data, 8'h41);
    repeat (6) step();

    // fill while scrolling
    scroll = 1'b1;
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h41 + i);
      step();
      if (font_we) strobes++;
    end
    wr_en = 1'b0;
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    check("fill_no_strobe", strobes, 0);

    // overflow handling
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    check("drop_ovf", overflow, 1);
    check("drop_count", count, 16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr2", overflow, 0);

    // release scroll with a push at full on the same edge as the first pop
    scroll = 1'b0; wr_en = 1'b1; wr_data = 8'h5B;
    step();
    wr_en = 1'b0;
    check("pop_drop_count", count, 15);
    check("pop_drop_ovf", overflow, 1);
    check("drain_we0", font_we, 1);
    check("drain_data0", font_data, 8'h41);
    got = 1; t_prev = 0;
    for (int c = 1; c < 72; c++) begin
      step();
      if (font_we) begin
        check($sformatf("drain_data%0d", got), font_data, 8'(8'h41 + got));
        check($sformatf("drain_gap%0d", got), c - t_prev, 4);
        t_prev = c;
        got++;
      end
    end
    check("drain_total", got, 16);
    check("drain_empty", empty, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // scroll raised during HOLD
    wr_en = 1'b1; wr_data = 8'h0A;
    step();
    wr_data = 8'h42;
    step();
    wr_en = 1'b0;
    check("scr_we", font_we, 1);
    check("scr_data", font_data, 8'h0A);
    scroll = 1'b1;
    strobes = 0;
    repeat (10) begin
      step();
      if (font_we) strobes++;
    end
    check("scr_paused", strobes, 0);
    check("scr_count", count, 1);
    scroll = 1'b0;
    wait_strobe(10, d, cyc, ok);
    check("scr_resume_ok", ok, 1);
    check("scr_resume_data", d, 8'h42);
    check("scr_resume_cyc", cyc, 2);
    repeat (6) step();

    // 40 characters interleaved with drain, pointers wrap twice
    k = 0;
    for (int c = 0; c < 260 && (k < 40 || q.size() > 0); c++) begin
      if (font_we) begin
        if (q.size() == 0) check("wrap_extra", 1, 0);
        else check("wrap_order", font_data, q.pop_front());
      end
      wr_en = 1'b0;
      if (k < 40 && c % 3 == 0) begin
        wr_en   = 1'b1;
        wr_data = (k == 0) ? 8'h08 : (k == 1) ? 8'h0A : (k == 2) ? 8'h0D : 8'(8'h30 + k);
        q.push_back(wr_data);
        k++;
      end
      step();
    end
    wr_en = 1'b0;
    check("wrap_pushed", k, 40);
    check("wrap_drained", q.size(), 0);
    check("wrap_ovf", overflow, 0);
    repeat (6) step();
    check("wrap_empty", empty, 1);

    // reset mid-ISSUE with count=5
    scroll = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      step();
    end
    wr_en = 1'b0;
    check("mr_count6", count, 6);
    scroll = 1'b0;
    step();
    check("mr_issue_we", font_we, 1);
    check("mr_issue_count", count, 5);
    #2 resetn = 1'b0;
    #1;
    check("mr_count", count, 0);
    check("mr_empty", empty, 1);
    check("mr_full", full, 0);
    check("mr_we", font_we, 0);
    check("mr_data", font_data, 8'h00);
    check("mr_ovf", overflow, 0);
    step();
    resetn = 1'b1;
    strobes = 0;
    repeat (20) begin
      step();
      if (font_we) strobes++;
    end
    check("mr_no_strobe", strobes, 0);
    check("mr_still_empty", empty, 1);
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    wait_strobe(10, d, cyc, ok);
    check("mr_new_ok", ok, 1);
    check("mr_new_data", d, 8'h55);
    check("mr_new_cyc", cyc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
